// File: rtl/p_hit_2.sv
// p_hit_2 - second hit-point stage of the ray/triangle pipeline.
// Joins t (Q16.16) from p_hit_1 with the matching ray origin/dir, computes
// p = origin + t*dir per axis and flags front hits (t > 0), then pushes
// {p, hit} to the output FIFO. Two register stages: multiply, then add.
// Optional feature: define P_HIT_SATURATE_EN to clamp p to the signed
// 32-bit range instead of wrapping.

module p_hit_2 #(
  parameter int Q_BITS     = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      t_dout,
  input  logic                       t_empty,
  output logic                       t_rd_en,
  input  logic [2:0][DATA_WIDTH-1:0] origin,
  input  logic [2:0][DATA_WIDTH-1:0] dir,
  input  logic                       ray_empty,
  output logic                       ray_rd_en,
  output logic [2:0][DATA_WIDTH-1:0] p,
  output logic                       hit,
  output logic                       out_wr_en,
  input  logic                       out_full
);

  localparam int PROD_W  = 2 * DATA_WIDTH;
  localparam int SHIFT_W = PROD_W - Q_BITS;
  localparam int SUM_W   = SHIFT_W + 1;

  logic                       stall;
  logic                       advance;
  logic                       fire;

  logic                       s1_valid;
  logic [2:0][SHIFT_W-1:0]    s1_shift;
  logic [2:0][DATA_WIDTH-1:0] s1_origin;
  logic [DATA_WIDTH-1:0]      s1_t;

  logic                       s2_valid;
  logic [2:0][DATA_WIDTH-1:0] p_next;
  logic                       hit_next;

`ifdef P_HIT_SATURATE_EN
  logic [2:0][SUM_W-1:0]      sum_wide;
`endif

  // Handshake: pop both input FIFOs together only when the pipe can move and we are out of reset
  always_comb begin
    stall     = s2_valid & out_full;
    advance   = ~stall;
    fire      = ~t_empty & ~ray_empty & advance & reset;
    t_rd_en   = fire;
    ray_rd_en = fire;
    out_wr_en = s2_valid & ~out_full & reset;
  end

  // Stage 1: full-width signed product t*dir, already shifted down by the fraction bits
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_shift  <= '0;
      s1_origin <= '0;
      s1_t      <= '0;
    end else if (advance) begin
      s1_valid <= fire;
      if (fire) begin
        for (int i = 0; i < 3; i++) begin
          s1_shift[i]  <= SHIFT_W'((PROD_W'($signed(t_dout)) * PROD_W'($signed(dir[i]))) >>> Q_BITS);
          s1_origin[i] <= origin[i];
        end
        s1_t <= t_dout;
      end
    end
  end

  // Stage 2 datapath: origin + scaled product, wrapped or clamped; hit only for strictly positive t
  always_comb begin
    p_next   = '0;
    hit_next = ~s1_t[DATA_WIDTH-1] & (|s1_t);
`ifdef P_HIT_SATURATE_EN
    sum_wide = '0;
`endif
    for (int i = 0; i < 3; i++) begin
`ifdef P_HIT_SATURATE_EN
      sum_wide[i] = SUM_W'($signed(s1_shift[i])) + SUM_W'($signed(s1_origin[i]));
      if ((&sum_wide[i][SUM_W-1:DATA_WIDTH-1]) | ~(|sum_wide[i][SUM_W-1:DATA_WIDTH-1])) begin
        p_next[i] = sum_wide[i][DATA_WIDTH-1:0];
      end else if (sum_wide[i][SUM_W-1]) begin
        p_next[i] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        p_next[i] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
`else
      p_next[i] = DATA_WIDTH'(SUM_W'($signed(s1_shift[i])) + SUM_W'($signed(s1_origin[i])));
`endif
    end
  end

  // Stage 2 register: holds its result while the output FIFO is full
  always_ff @(posedge clock) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      p        <= '0;
      hit      <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        p   <= p_next;
        hit <= hit_next;
      end
    end
  end

endmodule
